// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-bit CPU: widths, opcodes, instruction field positions and flags.
package cpu_pkg;

  localparam int DATA_W    = 5;
  localparam int INSTR_W   = 11;
  localparam int ADDR_W    = 3;
  localparam int NUM_REGS  = 4;
  localparam int RAM_DEPTH = 8;

  localparam int OP_HI    = 10;
  localparam int OP_LO    = 7;
  localparam int RA_HI    = 6;
  localparam int RA_LO    = 5;
  localparam int RB_HI    = 4;
  localparam int RB_LO    = 3;
  localparam int IMM_HI   = 4;
  localparam int IMM_LO   = 0;
  localparam int DADDR_HI = 4;
  localparam int DADDR_LO = 2;
  localparam int JADDR_HI = 6;
  localparam int JADDR_LO = 4;

  typedef enum logic [3:0] {
    OP_NOP   = 4'b0000,
    OP_JMP   = 4'b0001,
    OP_JE    = 4'b0010,
    OP_JG    = 4'b0011,
    OP_JL    = 4'b0100,
    OP_LOAD  = 4'b0101,
    OP_ROL   = 4'b0110,
    OP_ROR   = 4'b0111,
    OP_CMP   = 4'b1000,
    OP_SUB   = 4'b1001,
    OP_ADD   = 4'b1010,
    OP_ADDIN = 4'b1011,
    OP_STORE = 4'b1100,
    OP_AND   = 4'b1101,
    OP_OUT   = 4'b1110,
    OP_MOV   = 4'b1111
  } opcode_t;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } flags_t;

  // Rotations are modulo the data width, so any 5-bit immediate folds into 0..4.
  function automatic logic [2:0] rot_amount(input logic [DATA_W-1:0] imm);
    return 3'(imm % DATA_W);
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational datapath for the 5-bit CPU: add/sub/and, rotates and unsigned compare.
module cpu_alu
  import cpu_pkg::*;
(
  input  opcode_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output flags_t            flags
);

  localparam logic [2:0] DW3 = 3'(DATA_W);

  logic [2:0] rot;

  always_comb begin
    rot    = rot_amount(imm);
    result = a;
    case (op)
      OP_ADD, OP_ADDIN: result = a + b;
      OP_SUB:           result = a - b;
      OP_AND:           result = a & b;
      // A shift by the full width yields zero, which keeps rot==0 an identity.
      OP_ROL:           result = (a << rot) | (a >> (DW3 - rot));
      OP_ROR:           result = (a >> rot) | (a << (DW3 - rot));
      default:          result = a;
    endcase
    flags.eq = (a == b);
    flags.gt = (a > b);
    flags.lt = (a < b);
  end

endmodule

// File: rtl/cpu.sv
// Top of the single-cycle 5-bit CPU with unified program/data RAM.
// Define CPU_DEBUG_EN to expose REG0..REG3 and RAM0..RAM7 observation ports.
module cpu
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                PC_Enable,
  input  logic                RAM_Write_Enable,
  input  logic [ADDR_W-1:0]   RAM_Write_Address,
  input  logic [INSTR_W-1:0]  RAM_Write_Data,
  input  logic [DATA_W-1:0]   InD,
  input  logic                InE,
  output logic [DATA_W-1:0]   OutD,
  output logic [ADDR_W-1:0]   PC,
  output logic [INSTR_W-1:0]  PI
`ifdef CPU_DEBUG_EN
  ,
  output logic [DATA_W-1:0]   REG0,
  output logic [DATA_W-1:0]   REG1,
  output logic [DATA_W-1:0]   REG2,
  output logic [DATA_W-1:0]   REG3,
  output logic [INSTR_W-1:0]  RAM0,
  output logic [INSTR_W-1:0]  RAM1,
  output logic [INSTR_W-1:0]  RAM2,
  output logic [INSTR_W-1:0]  RAM3,
  output logic [INSTR_W-1:0]  RAM4,
  output logic [INSTR_W-1:0]  RAM5,
  output logic [INSTR_W-1:0]  RAM6,
  output logic [INSTR_W-1:0]  RAM7
`endif
);

  logic [INSTR_W-1:0] ram [RAM_DEPTH];
  logic [DATA_W-1:0]  regs [NUM_REGS];
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pc_inc;
  logic [ADDR_W-1:0]  pc_next;
  logic [DATA_W-1:0]  inr;
  logic [DATA_W-1:0]  out_d;
  flags_t             flags;

  logic [INSTR_W-1:0] instr;
  opcode_t            op;
  logic [1:0]         ra;
  logic [1:0]         rb;
  logic [DATA_W-1:0]  imm;
  logic [ADDR_W-1:0]  daddr;
  logic [ADDR_W-1:0]  jaddr;
  logic [DATA_W-1:0]  alu_b;
  logic [DATA_W-1:0]  alu_result;
  flags_t             alu_flags;

  assign instr = ram[pc];
  assign op    = opcode_t'(instr[OP_HI:OP_LO]);
  assign ra    = instr[RA_HI:RA_LO];
  assign rb    = instr[RB_HI:RB_LO];
  assign imm   = instr[IMM_HI:IMM_LO];
  assign daddr = instr[DADDR_HI:DADDR_LO];
  assign jaddr = instr[JADDR_HI:JADDR_LO];

  // ADDIN sums with the input latch instead of R[rb].
  assign alu_b = (op == OP_ADDIN) ? inr : regs[rb];

  cpu_alu u_alu (
    .op     (op),
    .a      (regs[ra]),
    .b      (alu_b),
    .imm    (imm),
    .result (alu_result),
    .flags  (alu_flags)
  );

  always_comb begin
    pc_inc  = pc + 3'd1;
    pc_next = pc_inc;
    case (op)
      OP_JMP:  pc_next = jaddr;
      OP_JE:   pc_next = flags.eq ? jaddr : pc_inc;
      OP_JG:   pc_next = flags.gt ? jaddr : pc_inc;
      OP_JL:   pc_next = flags.lt ? jaddr : pc_inc;
      default: pc_next = pc_inc;
    endcase
  end

  // External RAM writes take priority; execution only proceeds when no load is in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc    <= '0;
      inr   <= '0;
      out_d <= '0;
      flags <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      for (int i = 0; i < RAM_DEPTH; i++) ram[i] <= '0;
    end else begin
      if (InE) inr <= InD;
      if (RAM_Write_Enable) begin
        ram[RAM_Write_Address] <= RAM_Write_Data;
      end else if (PC_Enable) begin
        pc <= pc_next;
        case (op)
          OP_LOAD:  regs[ra] <= ram[daddr][DATA_W-1:0];
          OP_STORE: ram[daddr] <= {{(INSTR_W-DATA_W){1'b0}}, regs[ra]};
          OP_ROL, OP_ROR, OP_SUB, OP_ADD, OP_AND: regs[ra] <= alu_result;
          OP_ADDIN: regs[rb] <= alu_result;
          OP_CMP:   flags <= alu_flags;
          OP_OUT:   out_d <= regs[ra];
          OP_MOV:   regs[ra] <= regs[rb];
          default:  ;
        endcase
      end
    end
  end

  assign OutD = out_d;
  assign PC   = pc;
  assign PI   = instr;

`ifdef CPU_DEBUG_EN
  assign REG0 = regs[0];
  assign REG1 = regs[1];
  assign REG2 = regs[2];
  assign REG3 = regs[3];
  assign RAM0 = ram[0];
  assign RAM1 = ram[1];
  assign RAM2 = ram[2];
  assign RAM3 = ram[3];
  assign RAM4 = ram[4];
  assign RAM5 = ram[5];
  assign RAM6 = ram[6];
  assign RAM7 = ram[7];
`endif

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for the 5-bit CPU: directed programs plus random programs against an ISA-level model.
module tb_cpu;

  logic        clk;
  logic        reset;
  logic        PC_Enable;
  logic        RAM_Write_Enable;
  logic [2:0]  RAM_Write_Address;
  logic [10:0] RAM_Write_Data;
  logic [4:0]  InD;
  logic        InE;
  logic [4:0]  OutD;
  logic [2:0]  PC;
  logic [10:0] PI;
`ifdef CPU_DEBUG_EN
  logic [4:0]  REG0, REG1, REG2, REG3;
  logic [10:0] RAM0, RAM1, RAM2, RAM3, RAM4, RAM5, RAM6, RAM7;
`endif

  cpu dut (
    .clk               (clk),
    .reset             (reset),
    .PC_Enable         (PC_Enable),
    .RAM_Write_Enable  (RAM_Write_Enable),
    .RAM_Write_Address (RAM_Write_Address),
    .RAM_Write_Data    (RAM_Write_Data),
    .InD               (InD),
    .InE               (InE),
    .OutD              (OutD),
    .PC                (PC),
    .PI                (PI)
`ifdef CPU_DEBUG_EN
    ,
    .REG0 (REG0), .REG1 (REG1), .REG2 (REG2), .REG3 (REG3),
    .RAM0 (RAM0), .RAM1 (RAM1), .RAM2 (RAM2), .RAM3 (RAM3),
    .RAM4 (RAM4), .RAM5 (RAM5), .RAM6 (RAM6), .RAM7 (RAM7)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ISA-level reference state
  int m_ram [8];
  int m_reg [4];
  int m_pc, m_inr, m_out;
  bit m_e, m_g, m_l;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 8; i++) m_ram[i] = 0;
    for (int i = 0; i < 4; i++) m_reg[i] = 0;
    m_pc = 0; m_inr = 0; m_out = 0;
    m_e = 0; m_g = 0; m_l = 0;
  endtask

  task automatic modelStep(input bit pe, input bit we, input int wa, input int wd,
                           input bit ine, input int ind);
    int ins, op, ra, rb, imm, da, ja, nxt, a, b, n;
    if (we) begin
      m_ram[wa] = wd;
    end else if (pe) begin
      ins = m_ram[m_pc];
      op  = ins / 128;
      ra  = (ins / 32) % 4;
      rb  = (ins / 8) % 4;
      imm = ins % 32;
      da  = (ins / 4) % 8;
      ja  = (ins / 16) % 8;
      a   = m_reg[ra];
      b   = m_reg[rb];
      nxt = (m_pc + 1) % 8;
      case (op)
        1:  nxt = ja;
        2:  if (m_e) nxt = ja;
        3:  if (m_g) nxt = ja;
        4:  if (m_l) nxt = ja;
        5:  m_reg[ra] = m_ram[da] % 32;
        6:  begin
              n = imm % 5;
              for (int k = 0; k < n; k++) a = ((a * 2) % 32) + (a / 16);
              m_reg[ra] = a;
            end
        7:  begin
              n = imm % 5;
              for (int k = 0; k < n; k++) a = (a / 2) + (a % 2) * 16;
              m_reg[ra] = a;
            end
        8:  begin m_e = (a == b); m_g = (a > b); m_l = (a < b); end
        9:  m_reg[ra] = (a - b + 32) % 32;
        10: m_reg[ra] = (a + b) % 32;
        11: m_reg[rb] = (a + m_inr) % 32;
        12: m_ram[da] = a;
        13: m_reg[ra] = a & b;
        14: m_out = a;
        15: m_reg[ra] = b;
        default: ;
      endcase
      m_pc = nxt;
    end
    if (ine) m_inr = ind;
  endtask

  task automatic compareModel(input string where);
    checkOutput({where, ".PC"}, 32'(PC), 32'(m_pc));
    checkOutput({where, ".PI"}, 32'(PI), 32'(m_ram[m_pc]));
    checkOutput({where, ".OutD"}, 32'(OutD), 32'(m_out));
`ifdef CPU_DEBUG_EN
    checkOutput({where, ".REG0"}, 32'(REG0), 32'(m_reg[0]));
    checkOutput({where, ".REG1"}, 32'(REG1), 32'(m_reg[1]));
    checkOutput({where, ".REG2"}, 32'(REG2), 32'(m_reg[2]));
    checkOutput({where, ".REG3"}, 32'(REG3), 32'(m_reg[3]));
    checkOutput({where, ".RAM3"}, 32'(RAM3), 32'(m_ram[3]));
    checkOutput({where, ".RAM7"}, 32'(RAM7), 32'(m_ram[7]));
`endif
  endtask

  // One clock: drive inputs, update the model at the edge, compare 1 time unit later.
  task automatic applyStimulus(input bit pe, input bit we, input int wa, input int wd,
                               input bit ine, input int ind, input string where);
    PC_Enable = pe;
    RAM_Write_Enable = we;
    RAM_Write_Address = 3'(wa);
    RAM_Write_Data = 11'(wd);
    InE = ine;
    InD = 5'(ind);
    @(posedge clk);
    modelStep(pe, we, wa, wd, ine, ind);
    #1;
    compareModel(where);
  endtask

  task automatic loadWord(input int addr, input int data);
    applyStimulus(1'b0, 1'b1, addr, data, 1'b0, 0, "load");
  endtask

  task automatic runCycles(input int n, input string where);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 0, where);
  endtask

  // Asynchronous reset pulse placed between clock edges; outputs must clear immediately.
  task automatic doReset();
    reset = 1'b0;
    #2;
    modelReset();
    checkOutput("reset.PC", 32'(PC), 32'd0);
    checkOutput("reset.PI", 32'(PI), 32'd0);
    checkOutput("reset.OutD", 32'(OutD), 32'd0);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    PC_Enable = 1'b0;
    RAM_Write_Enable = 1'b0;
    RAM_Write_Address = '0;
    RAM_Write_Data = '0;
    InD = '0;
    InE = 1'b0;
    #1;
    doReset();

    // Loading while halted leaves PC at 0
    loadWord(3, 11'h403);
    checkOutput("load.pc_hold", 32'(PC), 32'd0);

    // ADDIN from input latch, OUT, STORE into RAM7, wrap
    doReset();
    applyStimulus(1'b0, 1'b1, 1, 11'b10110010000, 1'b1, 21, "load");
    loadWord(2, 11'b11101000000);
    loadWord(3, 11'b11001011100);
    runCycles(3, "addin");
    checkOutput("out.R2", 32'(OutD), 32'd21);
    runCycles(4, "store");
    checkOutput("store.pc7", 32'(PC), 32'd7);
    checkOutput("store.PI", 32'(PI), 32'd21);
    runCycles(1, "wrap");
    checkOutput("wrap.PC", 32'(PC), 32'd0);
    applyStimulus(1'b1, 1'b1, 6, 0, 1'b0, 0, "freeze");
    checkOutput("freeze.PC", 32'(PC), 32'd0);
    runCycles(2, "pre_reset");
    doReset();

    // CMP equal then JG not taken
    loadWord(0, 11'b01010011000);
    loadWord(1, 11'b01010111100);
    loadWord(2, 11'b10000001000);
    loadWord(3, 11'b00110010000);
    runCycles(4, "jg_eq");
    checkOutput("jg.not_taken", 32'(PC), 32'd4);

    // CMP 3 vs 1 then JG taken
    doReset();
    loadWord(0, 11'b01010011000);
    loadWord(1, 11'b01010111100);
    loadWord(2, 11'b10000001000);
    loadWord(3, 11'b00110010000);
    loadWord(6, 3);
    loadWord(7, 1);
    runCycles(4, "jg_gt");
    checkOutput("jg.taken", 32'(PC), 32'd1);

    // ROL by 2 then ROR by 7 (== 2)
    doReset();
    loadWord(0, 11'b01010011100);
    loadWord(1, 11'b01100000010);
    loadWord(2, 11'b11100000000);
    loadWord(3, 11'b01110000111);
    loadWord(4, 11'b11100000000);
    loadWord(7, 17);
    runCycles(3, "rol");
    checkOutput("rol.OutD", 32'(OutD), 32'd6);
    runCycles(2, "ror");
    checkOutput("ror.OutD", 32'(OutD), 32'd17);

    // Random programs with random halts, loads and input strobes
    for (int r = 0; r < 8; r++) begin
      doReset();
      for (int a = 0; a < 8; a++) loadWord(a, int'($urandom_range(0, 2047)));
      for (int c = 0; c < 60; c++) begin
        applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 11) == 0,
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 2047)),
                      $urandom_range(0, 1) == 1, int'($urandom_range(0, 31)), "rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
